alu_op_sequencer: RTL and testbench

- Front-end controller for the arithmetic cluster: carry-skip adder, carry-skip subtractor, Booth radix-4 multiplier and SRT radix-2 divider.
- Accepts one operation request at a time over a valid/ready handshake and registers the operands onto the shared operand bus.
- Starts the selected unit, waits its fixed latency, captures the result, and holds it on a valid/ready response channel.
- Sits between the instruction/test driver and the four arithmetic units; it is the only master of the operand bus.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_wait_ctr.sv | 28 ++
 rtl/alu_op_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM
// state encoding, default sizing and the wait-counter width helper.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_e;

   localparam int DEF_W          = 8;
   localparam int DEF_MUL_CYCLES = 4;
   localparam int DEF_DIV_CYCLES = 8;

   // Width needed to hold the larger of the two unit latencies.
   function automatic int ctr_width(input int mul_cycles, input int div_cycles);
      int mx;
      mx = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
      return $clog2(mx + 1);
   endfunction

   localparam int DEF_CTR_W = ctr_width(DEF_MUL_CYCLES, DEF_DIV_CYCLES);

endpackage

// File: rtl/alu_seq_wait_ctr.sv
// Loadable down-counter that times the multi-cycle units. done_at_one
// flags the last waiting cycle so the result can be captured on that edge.
module alu_seq_wait_ctr #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] value,
   output logic          done_at_one
);

   // Load takes priority over decrement; decrement never wraps below zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec && (value != '0)) begin
         value <= value - CW'(1);
      end
   end

   assign done_at_one = (value == CW'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the add/sub/mul/div cluster. Accepts one request,
// drives the operand bus, times the selected unit and holds the response.
// Optional build macro: DIV_ZERO_CHECK_EN short-circuits divide-by-zero.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int W          = DEF_W,
   parameter int MUL_CYCLES = DEF_MUL_CYCLES,
   parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     req_op,
   input  logic [W-1:0]   req_a,
   input  logic [W-1:0]   req_b,
   input  logic           req_cin,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [2*W-1:0] rsp_result,
   output logic           rsp_flag,
   output logic [W-1:0]   op_a,
   output logic [W-1:0]   op_b,
   output logic           op_cin,
   output logic           mul_start,
   output logic           div_start,
   input  logic [W-1:0]   add_sum,
   input  logic           add_cout,
   input  logic [W-1:0]   sub_diff,
   input  logic           sub_bout,
   input  logic [2*W-1:0] mul_prod,
   input  logic [W-1:0]   div_quot,
   input  logic [W-1:0]   div_rem,
   output logic           busy
);

   localparam int CW = ctr_width(MUL_CYCLES, DIV_CYCLES);

   state_e          state_reg;
   state_e          state_next;
   op_e             op_reg;
   logic            accept;
   logic            capture;
   logic            consume;
   logic            ctr_load;
   logic [CW-1:0]   ctr_load_val;
   logic            ctr_dec;
   logic [CW-1:0]   ctr_value;
   logic            ctr_done;
   logic            dz_bypass;
   logic            req_dz;
   logic [2*W-1:0]  cap_result;
   logic            cap_flag;

   assign req_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);

`ifdef DIV_ZERO_CHECK_EN
   logic divz_reg;

   // Remember at accept time whether the divisor was zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divz_reg <= 1'b0;
      end else if (accept) begin
         divz_reg <= (req_b == '0);
      end
   end

   assign req_dz    = (op_e'(req_op) == OP_DIV) && (req_b == '0);
   assign dz_bypass = (op_reg == OP_DIV) && divz_reg;
`else
   assign req_dz    = 1'b0;
   assign dz_bypass = 1'b0;
`endif

   alu_seq_wait_ctr #(
      .CW (CW)
   ) u_wait_ctr (
      .clk         (clk),
      .rst         (rst),
      .load        (ctr_load),
      .load_val    (ctr_load_val),
      .dec         (ctr_dec),
      .value       (ctr_value),
      .done_at_one (ctr_done)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and per-state control strobes.
   always_comb begin
      state_next   = state_reg;
      accept       = 1'b0;
      capture      = 1'b0;
      consume      = 1'b0;
      ctr_load     = 1'b0;
      ctr_load_val = '0;
      ctr_dec      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               accept     = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if ((op_reg == OP_ADD) || (op_reg == OP_SUB) || dz_bypass) begin
               capture    = 1'b1;
               state_next = RESP;
            end else begin
               ctr_load     = 1'b1;
               ctr_load_val = (op_reg == OP_MUL) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
               state_next   = WAIT;
            end
         end
         WAIT: begin
            ctr_dec = (ctr_value != '0);
            if (ctr_done) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               consume    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Result mux: selects the word and flag of the unit that was started.
   always_comb begin
      cap_result = '0;
      cap_flag   = 1'b0;
      case (op_reg)
         OP_ADD: begin
            cap_result = {{W{1'b0}}, add_sum};
            cap_flag   = add_cout;
         end
         OP_SUB: begin
            cap_result = {{W{1'b0}}, sub_diff};
            cap_flag   = sub_bout;
         end
         OP_MUL: begin
            cap_result = mul_prod;
            cap_flag   = 1'b0;
         end
         default: begin
            if (dz_bypass) begin
               cap_result = {op_a, {W{1'b1}}};
               cap_flag   = 1'b1;
            end else begin
               cap_result = {div_rem, div_quot};
               cap_flag   = 1'b0;
            end
         end
      endcase
   end

   // Operand bus and opcode register, loaded only when a request is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         op_cin <= 1'b0;
         op_reg <= OP_ADD;
      end else if (accept) begin
         op_a   <= req_a;
         op_b   <= req_b;
         op_cin <= req_cin;
         op_reg <= op_e'(req_op);
      end
   end

   // Start pulses are high only during the START cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_start <= 1'b0;
         div_start <= 1'b0;
      end else begin
         mul_start <= accept && (op_e'(req_op) == OP_MUL);
         div_start <= accept && (op_e'(req_op) == OP_DIV) && !req_dz;
      end
   end

   // Response channel: result captured once, held until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flag   <= 1'b0;
      end else if (capture) begin
         rsp_valid  <= 1'b1;
         rsp_result <= cap_result;
         rsp_flag   <= cap_flag;
      end else if (consume) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural arithmetic units, a
// transaction-level reference model checked every cycle, and directed
// operations with hand-computed results and latencies.
module tb_alu_op_sequencer;

   localparam int W  = 8;
   localparam int MC = 4;
   localparam int DC = 8;

   logic           clk;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [1:0]     req_op;
   logic [W-1:0]   req_a;
   logic [W-1:0]   req_b;
   logic           req_cin;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [2*W-1:0] rsp_result;
   logic           rsp_flag;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           op_cin;
   logic           mul_start;
   logic           div_start;
   logic [W-1:0]   add_sum;
   logic           add_cout;
   logic [W-1:0]   sub_diff;
   logic           sub_bout;
   logic [2*W-1:0] mul_prod;
   logic [W-1:0]   div_quot;
   logic [W-1:0]   div_rem;
   logic           busy;

   int tests = 0;
   int fails = 0;

`ifdef DIV_ZERO_CHECK_EN
   localparam bit DZ = 1'b1;
`else
   localparam bit DZ = 1'b0;
`endif

   alu_op_sequencer #(.W(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flag(rsp_flag),
      .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .mul_start(mul_start), .div_start(div_start),
      .add_sum(add_sum), .add_cout(add_cout),
      .sub_diff(sub_diff), .sub_bout(sub_bout),
      .mul_prod(mul_prod), .div_quot(div_quot), .div_rem(div_rem),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural arithmetic units ----------------
   // Multi-cycle units show garbage until their latency has elapsed.
   int mcnt = 0;
   int dcnt = 0;
   always @(posedge clk) begin
      if (mul_start) mcnt <= MC - 1;
      else if (mcnt > 0) mcnt <= mcnt - 1;
      if (div_start) dcnt <= DC - 1;
      else if (dcnt > 0) dcnt <= dcnt - 1;
   end

   logic [W:0] add_full;
   logic [W:0] sub_full;
   always_comb begin
      add_full = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};
      sub_full = {1'b0, op_a} - {1'b0, op_b} - {{W{1'b0}}, op_cin};
      add_sum  = add_full[W-1:0];
      add_cout = add_full[W];
      sub_diff = sub_full[W-1:0];
      sub_bout = sub_full[W];
      mul_prod = (mcnt == 0) ? (16'(op_a) * 16'(op_b)) : 16'hDEAD;
      if (dcnt != 0) begin
         div_quot = 8'hEE;
         div_rem  = 8'hEE;
      end else if (op_b == 0) begin
         div_quot = 8'hFF;
         div_rem  = op_a;
      end else begin
         div_quot = op_a / op_b;
         div_rem  = op_a % op_b;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [16:0] model_rsp(input logic [1:0] op, input int a, input int b, input int cin);
      int v;
      case (op)
         2'd0: begin
            v = a + b + cin;
            return {v > 255, 16'(v % 256)};
         end
         2'd1: begin
            v = a - b - cin;
            return {v < 0, 16'((v + 256) % 256)};
         end
         2'd2: return {1'b0, 16'(a * b)};
         default: begin
            if (b == 0) return {DZ, 16'(a * 256 + 255)};
            return {1'b0, 16'((a % b) * 256 + a / b)};
         end
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] op, input int b);
      if (op == 2'd2) return 1 + MC;
      if (op == 2'd3) return (DZ && b == 0) ? 1 : 1 + DC;
      return 1;
   endfunction

   logic        m_busy, m_valid, m_ms, m_ds, m_cin, m_flag, p_flag;
   logic [7:0]  m_a, m_b;
   logic [15:0] m_res, p_res;
   int          m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_valid <= 0; m_ms <= 0; m_ds <= 0; m_cin <= 0;
         m_a <= 0; m_b <= 0; m_res <= 0; m_flag <= 0; m_cnt <= 0;
         p_res <= 0; p_flag <= 0;
      end else begin
         m_ms <= 1'b0;
         m_ds <= 1'b0;
         if (!m_busy) begin
            if (req_valid) begin
               m_busy <= 1'b1;
               m_a <= req_a; m_b <= req_b; m_cin <= req_cin;
               m_cnt <= model_lat(req_op, int'(req_b));
               {p_flag, p_res} <= model_rsp(req_op, int'(req_a), int'(req_b), int'(req_cin));
               m_ms <= (req_op == 2'd2);
               m_ds <= (req_op == 2'd3) && !(DZ && req_b == 0);
            end
         end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_valid <= 1'b1;
               m_res   <= p_res;
               m_flag  <= p_flag;
            end
         end else if (rsp_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("req_ready", 32'(req_ready), 32'(!m_busy));
         chk("busy",      32'(busy),      32'(m_busy));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
         chk("mul_start", 32'(mul_start), 32'(m_ms));
         chk("div_start", 32'(div_start), 32'(m_ds));
         chk("op_a",      32'(op_a),      32'(m_a));
         chk("op_b",      32'(op_b),      32'(m_b));
         chk("op_cin",    32'(op_cin),    32'(m_cin));
         if (m_valid) begin
            chk("rsp_result", 32'(rsp_result), 32'(m_res));
            chk("rsp_flag",   32'(rsp_flag),   32'(m_flag));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_op(input string name, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input logic [15:0] exp_res,
                        input logic exp_flag, input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a = 8'hA5; req_b = 8'h5A; req_op = ~op; req_cin = ~cin;
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " result"},  32'(rsp_result), 32'(exp_res));
      chk({name, " flag"},    32'(rsp_flag), 32'(exp_flag));
      repeat (hold) begin
         @(posedge clk);
         #1;
         chk({name, " hold result"}, 32'(rsp_result), 32'(exp_res));
         chk({name, " hold valid"},  32'(rsp_valid), 32'd1);
         chk({name, " hold ready"},  32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      $display("[TB] %s a=%0d b=%0d cin=%0d -> result=0x%04h flag=%0d latency=%0d",
               name, a, b, cin, exp_res, exp_flag, lat);
   endtask

   initial begin
      rst = 1'b1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_cin = 0; rsp_ready = 0;
      #1;
      chk("reset rsp_valid",  32'(rsp_valid), 32'd0);
      chk("reset busy",       32'(busy), 32'd0);
      chk("reset req_ready",  32'(req_ready), 32'd1);
      chk("reset rsp_result", 32'(rsp_result), 32'd0);
      chk("reset op_a",       32'(op_a), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      do_op("ADD 100+24",  2'd0, 8'd100, 8'd24,  1'b0, 16'h007C, 1'b0, 1, 0);
      do_op("ADD 200+100", 2'd0, 8'd200, 8'd100, 1'b0, 16'h002C, 1'b1, 1, 0);
      do_op("ADD 1+1+cin", 2'd0, 8'd1,   8'd1,   1'b1, 16'h0003, 1'b0, 1, 0);
      do_op("SUB 100-24",  2'd1, 8'd100, 8'd24,  1'b0, 16'h004C, 1'b0, 1, 0);
      do_op("SUB 24-100",  2'd1, 8'd24,  8'd100, 1'b0, 16'h00B4, 1'b1, 1, 0);
      do_op("MUL 100*24",  2'd2, 8'd100, 8'd24,  1'b0, 16'h0960, 1'b0, 1 + MC, 0);
      do_op("MUL 255*255", 2'd2, 8'd255, 8'd255, 1'b1, 16'hFE01, 1'b0, 1 + MC, 1);
      do_op("DIV 12/10",   2'd3, 8'd12,  8'd10,  1'b0, 16'h0201, 1'b0, 1 + DC, 3);
      do_op("DIV 50/0",    2'd3, 8'd50,  8'd0,   1'b0, 16'h32FF, DZ, DZ ? 1 : 1 + DC, 0);

      // Reset asserted asynchronously in the middle of a DIV wait.
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd3; req_a = 8'd12; req_b = 8'd10; req_cin = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async rst busy",      32'(busy), 32'd0);
      chk("async rst req_ready", 32'(req_ready), 32'd1);
      chk("async rst op_a",      32'(op_a), 32'd0);
      chk("async rst op_b",      32'(op_b), 32'd0);
      chk("async rst div_start", 32'(div_start), 32'd0);
      chk("async rst result",    32'(rsp_result), 32'd0);
      chk("async rst flag",      32'(rsp_flag), 32'd0);
      $display("[TB] async reset during DIV wait -> outputs cleared");
      @(negedge clk);
      rst = 1'b0;

      do_op("ADD after reset", 2'd0, 8'd1, 8'd1, 1'b0, 16'h0002, 1'b0, 1, 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
